// File: rtl/gcd_lcm_datapath.sv
// gcd_lcm_datapath
//
// This is the operand datapath for the GCD/LCM sequencing controller.
// It holds the working registers x and y and the original operands
// a_reg and b_reg. It carries out the controller's load, subtract and
// add strobes, and it returns x and y to the controller for comparison.
// When done is asserted, the current x is captured into a one-entry
// result buffer. The buffer uses a valid/ready handshake, and the sticky
// error flags are captured along with the result.
//
// Parameters
//   W         operand/result width in bits (must match controller x/y width)
//   MAX_ITER  add/subtract strobe count at which timeout sets
//
// Ports
//   clk         clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   a_in        first operand, sampled on load_x
//   b_in        second operand, sampled on load_y
//   load_x      x <= a_in, a_reg <= a_in
//   load_y      y <= b_in, b_reg <= b_in
//   subtract_x  x <= x - y
//   subtract_y  y <= y - x
//   add_x       x <= x + a_reg
//   add_y       y <= y + b_reg
//   done        controller done; current x is the result
//   x, y        working registers, to controller
//   res_data    buffered result
//   res_flags   {timeout, zero_err, ovf} captured with res_data
//   res_valid   result buffer occupied
//   res_ready   consumer accepts res_data when res_valid && res_ready
//   overrun     sticky: a done arrived while the buffer was full
//   busy        high from the first load until done is captured
module gcd_lcm_datapath #(
  parameter int W        = 8,
  parameter int MAX_ITER = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         load_x,
  input  logic         load_y,
  input  logic         subtract_x,
  input  logic         subtract_y,
  input  logic         add_x,
  input  logic         add_y,
  input  logic         done,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_flags,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);

  logic [W-1:0]  x_reg;
  logic [W-1:0]  y_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [CW-1:0] iter_cnt;
  logic          ovf;
  logic          zero_err;
  logic          timeout;

  logic [W:0]    sum_x;
  logic [W:0]    sum_y;
  logic [W-1:0]  a_next;
  logic [W-1:0]  b_next;
  logic          any_load;
  logic          any_step;
  logic          carry_x;
  logic          carry_y;
  logic          can_accept;

  assign x = x_reg;
  assign y = y_reg;

  // The sums are one bit wider than the operands. The extra top bit is the
  // carry that sets ovf.
  assign sum_x = {1'b0, x_reg} + {1'b0, a_reg};
  assign sum_y = {1'b0, y_reg} + {1'b0, b_reg};

  // An add counts toward overflow only when it actually updates its
  // register. A load or subtract on the same register overrides it.
  assign carry_x = add_x && !load_x && !subtract_x && sum_x[W];
  assign carry_y = add_y && !load_y && !subtract_y && sum_y[W];

  assign any_load = load_x || load_y;
  assign any_step = subtract_x || subtract_y || add_x || add_y;

  // These are the operand registers as they will be after this edge. The
  // zero check looks at both operands once the load has taken effect.
  assign a_next = load_x ? a_in : a_reg;
  assign b_next = load_y ? b_in : b_reg;

  // The buffer can take a new result if it is empty, or if it is being
  // popped in this same cycle.
  assign can_accept = !res_valid || res_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      iter_cnt  <= '0;
      ovf       <= 1'b0;
      zero_err  <= 1'b0;
      timeout   <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // x and y both update from their pre-edge values, so a subtract
      // on each register in the same cycle uses the old x and y.
      if (load_x)          x_reg <= a_in;
      else if (subtract_x) x_reg <= x_reg - y_reg;
      else if (add_x)      x_reg <= sum_x[W-1:0];

      if (load_y)          y_reg <= b_in;
      else if (subtract_y) y_reg <= y_reg - x_reg;
      else if (add_y)      y_reg <= sum_y[W-1:0];

      if (load_x) a_reg <= a_in;
      if (load_y) b_reg <= b_in;

      // A load starts a new operation. Otherwise each strobe cycle
      // advances the iteration count until it saturates at MAX_ITER.
      if (any_load) begin
        ovf      <= 1'b0;
        timeout  <= 1'b0;
        iter_cnt <= '0;
        zero_err <= (a_next == '0) || (b_next == '0);
      end else begin
        if (carry_x || carry_y) ovf <= 1'b1;
        if (any_step && (iter_cnt != CW'(MAX_ITER))) begin
          iter_cnt <= iter_cnt + CW'(1);
          if (iter_cnt == CW'(MAX_ITER - 1)) timeout <= 1'b1;
        end
      end

      if (done) begin
        if (can_accept) begin
          res_data  <= x_reg;
          res_flags <= {timeout, zero_err, ovf};
          res_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      // The busy update for a load comes after the one for done, so a
      // load in the same cycle as done starts the next operation.
      if (done)     busy <= 1'b0;
      if (any_load) busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcd_lcm_datapath.sv
// tb_gcd_lcm_datapath
//
// This is a directed bench for gcd_lcm_datapath. Its main part is a table
// of single-cycle vectors with hand-computed expected values. Each vector
// gives the strobes to apply and the expected x, y, busy and result
// buffer contents after that edge. Sequences written by hand cover the
// timeout boundary, backpressure/overrun, and reset in the middle of an
// operation.
module tb_gcd_lcm_datapath;

  localparam int W = 8;

  // ctl bit order: {load_x, load_y, subtract_x, subtract_y, add_x, add_y, done, res_ready}
  localparam logic [7:0] C_LOAD = 8'b1100_0001;
  localparam logic [7:0] C_LX   = 8'b1000_0000;
  localparam logic [7:0] C_SX   = 8'b0010_0001;
  localparam logic [7:0] C_SY   = 8'b0001_0001;
  localparam logic [7:0] C_SXY  = 8'b0011_0001;
  localparam logic [7:0] C_AX   = 8'b0000_1001;
  localparam logic [7:0] C_AY   = 8'b0000_0101;
  localparam logic [7:0] C_DONE = 8'b0000_0011;
  localparam logic [7:0] C_DNR  = 8'b0000_0010;
  localparam logic [7:0] C_POP  = 8'b0000_0001;
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_PRIO = 8'b1110_0101;

  typedef struct {
    string        name;
    logic [7:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_x;
    logic [W-1:0] exp_y;
    logic         exp_busy;
    logic         chk_res;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_flags;
  } vec_t;

  localparam int NVEC = 19;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_in, b_in;
  logic         load_x, load_y, subtract_x, subtract_y, add_x, add_y, done;
  logic [W-1:0] x, y, res_data;
  logic [2:0]   res_flags;
  logic         res_valid, res_ready, overrun, busy;

  int check_count = 0;
  int pass_count  = 0;
  vec_t tbl [NVEC];

  gcd_lcm_datapath #(.W(W), .MAX_ITER(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .b_in       (b_in),
    .load_x     (load_x),
    .load_y     (load_y),
    .subtract_x (subtract_x),
    .subtract_y (subtract_y),
    .add_x      (add_x),
    .add_y      (add_y),
    .done       (done),
    .x          (x),
    .y          (y),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drives one cycle of control, steps past the rising edge, and then
  // drops all strobes so that outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input logic [7:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
    {load_x, load_y, subtract_x, subtract_y, add_x, add_y, done, res_ready} = ctl;
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
    {load_x, load_y, subtract_x, subtract_y, add_x, add_y, done, res_ready} = C_IDLE;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    {load_x, load_y, subtract_x, subtract_y, add_x, add_y, done, res_ready} = C_IDLE;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, " x"}, 32'(x), 0);
    check_output({tag, " y"}, 32'(y), 0);
    check_output({tag, " res_valid"}, 32'(res_valid), 0);
    check_output({tag, " res_data"}, 32'(res_data), 0);
    check_output({tag, " res_flags"}, 32'(res_flags), 0);
    check_output({tag, " busy"}, 32'(busy), 0);
    check_output({tag, " overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    // GCD 48,18
    tbl[0]  = '{"gcd load",     C_LOAD, 8'd48,  8'd18,  8'd48,  8'd18,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[1]  = '{"gcd sx1",      C_SX,   8'd0,   8'd0,   8'd30,  8'd18,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[2]  = '{"gcd sx2",      C_SX,   8'd0,   8'd0,   8'd12,  8'd18,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[3]  = '{"gcd sy",       C_SY,   8'd0,   8'd0,   8'd12,  8'd6,   1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[4]  = '{"gcd sx3",      C_SX,   8'd0,   8'd0,   8'd6,   8'd6,   1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[5]  = '{"gcd done",     C_DONE, 8'd0,   8'd0,   8'd6,   8'd6,   1'b0, 1'b1, 1'b1, 8'd6,   3'b000};
    // LCM 4,6; the load cycle also pops the GCD result
    tbl[6]  = '{"lcm load",     C_LOAD, 8'd4,   8'd6,   8'd4,   8'd6,   1'b1, 1'b1, 1'b0, 8'd6,   3'b000};
    tbl[7]  = '{"lcm ax1",      C_AX,   8'd0,   8'd0,   8'd8,   8'd6,   1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[8]  = '{"lcm ay",       C_AY,   8'd0,   8'd0,   8'd8,   8'd12,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[9]  = '{"lcm ax2",      C_AX,   8'd0,   8'd0,   8'd12,  8'd12,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[10] = '{"lcm done",     C_DONE, 8'd0,   8'd0,   8'd12,  8'd12,  1'b0, 1'b1, 1'b1, 8'd12,  3'b000};
    // simultaneous subtracts use old values; y wraps 3-10 = 249
    tbl[11] = '{"sim load",     C_LOAD, 8'd10,  8'd3,   8'd10,  8'd3,   1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[12] = '{"sim sxy",      C_SXY,  8'd0,   8'd0,   8'd7,   8'd249, 1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    // load beats subtract/add on the same register
    tbl[13] = '{"prio load",    C_PRIO, 8'd9,   8'd9,   8'd9,   8'd9,   1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    // overflow: 150+150 = 300 -> 44
    tbl[14] = '{"ovf load",     C_LOAD, 8'd200, 8'd150, 8'd200, 8'd150, 1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[15] = '{"ovf ay",       C_AY,   8'd0,   8'd0,   8'd200, 8'd44,  1'b1, 1'b0, 1'b0, 8'd0,   3'b000};
    tbl[16] = '{"ovf done",     C_DONE, 8'd0,   8'd0,   8'd200, 8'd44,  1'b0, 1'b1, 1'b1, 8'd200, 3'b001};
    tbl[17] = '{"ovf reload",   C_LOAD, 8'd200, 8'd150, 8'd200, 8'd150, 1'b1, 1'b1, 1'b0, 8'd200, 3'b001};
    tbl[18] = '{"ovf cleared",  C_DONE, 8'd0,   8'd0,   8'd200, 8'd150, 1'b0, 1'b1, 1'b1, 8'd200, 3'b000};

    reset = 1'b1;
    a_in = '0;
    b_in = '0;
    {load_x, load_y, subtract_x, subtract_y, add_x, add_y, done, res_ready} = C_IDLE;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("reset");

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(tbl[i].ctl, tbl[i].a, tbl[i].b);
      check_output({tbl[i].name, " x"}, 32'(x), 32'(tbl[i].exp_x));
      check_output({tbl[i].name, " y"}, 32'(y), 32'(tbl[i].exp_y));
      check_output({tbl[i].name, " busy"}, 32'(busy), 32'(tbl[i].exp_busy));
      if (tbl[i].chk_res) begin
        check_output({tbl[i].name, " res_valid"}, 32'(res_valid), 32'(tbl[i].exp_valid));
        check_output({tbl[i].name, " res_data"}, 32'(res_data), 32'(tbl[i].exp_data));
        check_output({tbl[i].name, " res_flags"}, 32'(res_flags), 32'(tbl[i].exp_flags));
      end
    end

    // Zero operand and timeout boundary: after 254 strobes timeout is still
    // clear, and the 255th strobe sets it.
    apply_stimulus(C_LOAD, 8'd0, 8'd5);
    for (int i = 0; i < 254; i++) apply_stimulus(C_SY, 8'd0, 8'd0);
    check_output("tmo y held", 32'(y), 5);
    apply_stimulus(C_DONE, 8'd0, 8'd0);
    check_output("tmo 254 flags", 32'(res_flags), 32'(3'b010));
    check_output("tmo 254 data", 32'(res_data), 0);
    apply_stimulus(C_SY, 8'd0, 8'd0);
    apply_stimulus(C_SY, 8'd0, 8'd0);
    apply_stimulus(C_DONE, 8'd0, 8'd0);
    check_output("tmo 255 flags", 32'(res_flags), 32'(3'b110));
    check_output("tmo 255 valid", 32'(res_valid), 1);

    // Backpressure and overrun
    apply_stimulus(C_POP, 8'd0, 8'd0);
    check_output("bp pop empty", 32'(res_valid), 0);
    apply_stimulus(C_LX, 8'd9, 8'd0);
    apply_stimulus(C_DNR, 8'd0, 8'd0);
    check_output("bp first data", 32'(res_data), 9);
    check_output("bp first valid", 32'(res_valid), 1);
    check_output("bp first overrun", 32'(overrun), 0);
    apply_stimulus(C_LX, 8'd3, 8'd0);
    check_output("bp busy set", 32'(busy), 1);
    apply_stimulus(C_DNR, 8'd0, 8'd0);
    check_output("bp held data", 32'(res_data), 9);
    check_output("bp overrun", 32'(overrun), 1);
    check_output("bp busy cleared", 32'(busy), 0);
    apply_stimulus(C_POP, 8'd0, 8'd0);
    check_output("bp popped", 32'(res_valid), 0);
    apply_stimulus(C_DNR, 8'd0, 8'd0);
    check_output("bp refill data", 32'(res_data), 3);
    apply_stimulus(C_LX, 8'd7, 8'd0);
    apply_stimulus(C_DONE, 8'd0, 8'd0);
    check_output("bp done+pop data", 32'(res_data), 7);
    check_output("bp done+pop valid", 32'(res_valid), 1);
    check_output("bp overrun sticky", 32'(overrun), 1);

    // Reset in the middle of a GCD run, then a clean rerun
    apply_stimulus(8'b1100_0000, 8'd48, 8'd18);
    apply_stimulus(8'b0010_0000, 8'd0, 8'd0);
    apply_stimulus(8'b0010_0000, 8'd0, 8'd0);
    check_output("mid x", 32'(x), 12);
    pulse_reset();
    check_cleared("midreset");
    for (int i = 0; i <= 5; i++) apply_stimulus(tbl[i].ctl, tbl[i].a, tbl[i].b);
    check_output("rerun data", 32'(res_data), 6);
    check_output("rerun flags", 32'(res_flags), 0);
    check_output("rerun valid", 32'(res_valid), 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
